// File: rtl/sha256_round_engine.sv
// rtl/sha256_round_engine.sv - SHA-256 compression round engine, RPC rounds per accepted schedule beat
module sha256_round_engine #(
    parameter int RPC    = 1,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [255:0]      init_state,
    input  logic              w_valid,
    input  logic [32*RPC-1:0] w_data,
    output logic              w_ready,
    output logic              busy,
    output logic              done,
    output logic [255:0]      digest
);

    localparam int CW = ($clog2(ROUNDS + 1) > 7) ? $clog2(ROUNDS + 1) : 7;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [255:0]    h_reg;
    logic [255:0]    work;
    logic [CW-1:0]   cnt;
    logic [255:0]    digest_q;
    logic [255:0]    sum;
    logic [255:0]    chain [RPC+1];
    logic            beat;
    logic            last_beat;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    assign beat      = w_valid && (state == ST_RUN);
    assign last_beat = (cnt + CW'(RPC)) == CW'(ROUNDS);

    // RPC rounds chained combinationally; W[t] sits in the least significant word of the beat
    always_comb begin
        chain[0] = work;
        for (int i = 0; i < RPC; i++) begin
            chain[i+1] = sha_round(chain[i], K_TABLE[cnt[5:0] + 6'(i)], w_data[32*i +: 32]);
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < 8; j++) begin
            sum[32*j +: 32] = h_reg[32*j +: 32] + work[32*j +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                  state_next = ST_IDLE;
                else if (beat && last_beat) state_next = ST_FINAL;
            end
            ST_FINAL: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // The final sum is bypassed onto digest during FINAL so done and digest coincide
    always_comb begin
        w_ready = (state == ST_RUN);
        busy    = (state != ST_IDLE);
        done    = (state == ST_FINAL) && !abort;
        digest  = done ? sum : digest_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg    <= '0;
            work     <= '0;
            cnt      <= '0;
            digest_q <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                h_reg <= init_state;
                work  <= init_state;
                cnt   <= '0;
            end else if (beat && !abort) begin
                work <= chain[RPC];
                cnt  <= cnt + CW'(RPC);
            end
            if (state == ST_FINAL && !abort) begin
                digest_q <= sum;
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb/tb_sha256_round_engine.sv - scoreboard bench for sha256_round_engine (RPC=1 and RPC=4 instances)
module tb_sha256_round_engine;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_M1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_M2 = {{15{32'h00000000}}, 32'h000001c0};

    typedef struct {
        logic [255:0] dg;
        bit           chk;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start1 = 1'b0, abort1 = 1'b0, w_valid1 = 1'b0;
    logic [31:0]  w_data1 = '0;
    logic [255:0] init1 = '0;
    logic         w_ready1, busy1, done1;
    logic [255:0] digest1;
    logic         start4 = 1'b0, abort4 = 1'b0, w_valid4 = 1'b0;
    logic [127:0] w_data4 = '0;
    logic [255:0] init4 = '0;
    logic         w_ready4, busy4, done4;
    logic [255:0] digest4;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           beats4 = 0;
    exp_t         q1[$];
    exp_t         q4[$];
    logic [31:0]  wsched [64];

    sha256_round_engine #(.RPC(1), .ROUNDS(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .init_state(init1),
        .w_valid(w_valid1), .w_data(w_data1), .w_ready(w_ready1), .busy(busy1),
        .done(done1), .digest(digest1)
    );

    sha256_round_engine #(.RPC(4), .ROUNDS(64)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .init_state(init4),
        .w_valid(w_valid4), .w_data(w_data4), .w_ready(w_ready4), .busy(busy4),
        .done(done4), .digest(digest4)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, want $finish before 200000 ns");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic mon_done(input int sel, input logic [255:0] dg);
        exp_t e;
        if ((sel == 1) ? (q1.size() == 0) : (q4.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done_dut%0d: got done at cycle %0d digest %h want no done", sel, cyc, dg);
            return;
        end
        e = (sel == 1) ? q1.pop_front() : q4.pop_front();
        if (e.chk) check($sformatf("digest_dut%0d", sel), dg, e.dg);
        check($sformatf("done_cycle_dut%0d", sel), 256'(cyc), 256'(e.cyc));
    endtask

    // Monitor: samples outputs on the falling edge, away from input changes
    initial forever begin
        @(negedge clk);
        if (w_valid4 && w_ready4) beats4++;
        if (done1) mon_done(1, digest1);
        if (done4) mon_done(4, digest4);
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic expand(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) wsched[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            wsched[t] = (rr(wsched[t-2], 17) ^ rr(wsched[t-2], 19) ^ (wsched[t-2] >> 10)) + wsched[t-7]
                      + (rr(wsched[t-15], 7) ^ rr(wsched[t-15], 18) ^ (wsched[t-15] >> 3)) + wsched[t-16];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input logic ab, input logic v, input int t);
        if (sel == 4) begin
            start4 = st; abort4 = ab; w_valid4 = v;
            w_data4 = v ? {wsched[t+3], wsched[t+2], wsched[t+1], wsched[t]} : '0;
        end else begin
            start1 = st; abort1 = ab; w_valid1 = v;
            w_data1 = v ? wsched[t] : '0;
        end
    endtask

    // Issues one block; abort_at >= 0 cancels with a beat after that many beats
    task automatic run_block(input int sel, input logic [255:0] iv, input logic [511:0] blk,
                             input bit gaps, input int abort_at, input bit poke,
                             input logic [255:0] exp_dg, input bit chk);
        int   nb, stalls;
        int   gap [64];
        exp_t e;
        expand(blk);
        nb = 64 / sel;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
            gap[b] = gaps ? int'($urandom_range(0, 2)) : 0;
            stalls += gap[b];
        end
        if (sel == 4) init4 = iv; else init1 = iv;
        if (abort_at < 0) begin
            e.dg = exp_dg; e.chk = chk; e.cyc = cyc + 1 + nb + stalls;
            if (sel == 4) q4.push_back(e); else q1.push_back(e);
        end
        drive(sel, 1'b1, 1'b0, 1'b0, 0);
        tick();
        for (int b = 0; b < nb; b++) begin
            repeat (gap[b]) begin
                drive(sel, 1'b0, 1'b0, 1'b0, 0);
                tick();
            end
            if (b == abort_at) begin
                drive(sel, 1'b0, 1'b1, 1'b1, b * sel);
                tick();
                drive(sel, 1'b0, 1'b0, 1'b0, 0);
                return;
            end
            drive(sel, poke && (b == 5 || b == 40), 1'b0, 1'b1, b * sel);
            tick();
        end
        drive(sel, poke, 1'b0, 1'b0, 0);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic [255:0] mid;
        int           b0;
        repeat (2) tick();
        check("reset_w_ready1", 256'(w_ready1), 256'(0));
        check("reset_busy1", 256'(busy1), 256'(0));
        check("reset_done1", 256'(done1), 256'(0));
        check("reset_digest1", digest1, 256'(0));
        check("reset_w_ready4", 256'(w_ready4), 256'(0));
        check("reset_digest4", digest4, 256'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        run_block(1, IV, BLK_ABC, 1'b0, -1, 1'b0, ABC_DG, 1'b1);
        repeat (3) tick();

        b0 = beats4;
        run_block(4, IV, BLK_ABC, 1'b1, -1, 1'b0, ABC_DG, 1'b1);
        repeat (3) tick();
        check("beats_rpc4", 256'(beats4 - b0), 256'(16));
        check("digest_hold4", digest4, ABC_DG);

        run_block(1, IV, BLK_M1, 1'b0, -1, 1'b0, '0, 1'b0);
        repeat (2) tick();
        mid = digest1;
        run_block(1, mid, BLK_M2, 1'b0, -1, 1'b0, TWO_DG, 1'b1);
        repeat (2) tick();

        run_block(1, IV, BLK_ABC, 1'b0, 10, 1'b0, '0, 1'b0);
        check("abort_busy", 256'(busy1), 256'(0));
        check("abort_digest_kept", digest1, TWO_DG);
        run_block(1, IV, BLK_ABC, 1'b0, -1, 1'b0, ABC_DG, 1'b1);
        repeat (3) tick();

        run_block(1, IV, BLK_M2, 1'b0, -1, 1'b1, 256'hde5e9e1c_8e4c6d8e_37b6fb81_70a64208_c47ee1b5_b4b6ae5d_9d86ecd8_52c1e436, 1'b0);
        repeat (2) tick();
        run_block(1, IV, BLK_ABC, 1'b0, -1, 1'b1, ABC_DG, 1'b1);
        repeat (3) tick();
        check("poke_idle_after", 256'(busy1), 256'(0));

        expand(BLK_ABC);
        init1 = IV;
        drive(1, 1'b1, 1'b0, 1'b0, 0);
        tick();
        for (int b = 0; b < 30; b++) begin
            drive(1, 1'b0, 1'b0, 1'b1, b);
            tick();
        end
        rst_n = 1'b0;
        drive(1, 1'b1, 1'b0, 1'b1, 30);
        #1;
        check("rst_mid_w_ready", 256'(w_ready1), 256'(0));
        check("rst_mid_busy", 256'(busy1), 256'(0));
        check("rst_mid_done", 256'(done1), 256'(0));
        check("rst_mid_digest", digest1, 256'(0));
        repeat (3) tick();
        check("rst_hold_busy", 256'(busy1), 256'(0));
        rst_n = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b1, 31);
        repeat (3) begin
            tick();
            check("rst_after_w_ready", 256'(w_ready1), 256'(0));
        end
        check("rst_after_busy", 256'(busy1), 256'(0));
        drive(1, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) tick();

        check("sb_empty_dut1", 256'(q1.size()), 256'(0));
        check("sb_empty_dut4", 256'(q4.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 SHALL have parameter RPC, default 1, meaning rounds per accepted beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter ROUNDS, default 64, meaning total rounds per block; must be a multiple of RPC.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begin a block; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the block in progress.
REQ-007 SHALL have port init_state  input  256  chaining value H0..H7, H0 in bits [255:224].
REQ-008 SHALL have port w_valid  input  1  message-schedule beat valid.
REQ-009 SHALL have port w_data  input  32*RPC  schedule words W[t]..W[t+RPC-1], W[t] in the least significant word.
REQ-010 SHALL have port w_ready  output  1  engine accepts a schedule beat this cycle.
REQ-011 SHALL have port busy  output  1  block in progress.
REQ-012 SHALL have port done  output  1  single-cycle pulse; digest is valid.
REQ-013 SHALL have port digest  output  256  updated chaining value, H0 in bits [255:224].

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> FINAL -> IDLE.
REQ-015 In IDLE with start=1, SHALL latch init_state into chaining registers H and working registers A..H, clear the round counter, and enter RUN.
REQ-016 SHALL drive w_ready=1 only in RUN; a beat is accepted when w_valid && w_ready.
REQ-017 Per accepted beat, SHALL apply RPC chained FIPS 180-4 rounds using Ch(e,f,g)=(e&f)^(~e&g), Maj, Σ0, Σ1 and the internal K[t] ROM, and SHALL advance the counter by RPC.
REQ-018 SHALL hold the working registers and counter unchanged in RUN cycles with no accepted beat; stalls are unbounded.
REQ-019 SHALL enter FINAL on the beat that brings the counter to ROUNDS.
REQ-020 In FINAL, SHALL register digest = H + working registers, word-wise modulo 2^32 with carries discarded, pulse done for exactly that one cycle, then return to IDLE.
REQ-021 SHALL hold digest until the next FINAL; start, abort and new beats SHALL NOT alter it.
REQ-022 SHALL assert busy in RUN and FINAL, and deassert it in IDLE.
REQ-023 SHALL ignore start outside IDLE; start and done may coincide only as done-then-next-cycle start.
REQ-024 abort=1 in RUN or FINAL SHALL return the FSM to IDLE next cycle with no done and digest unchanged; abort SHALL take priority over a simultaneous beat; abort in IDLE SHALL have no effect.
REQ-025 Latency from the accepting edge of start to done: (ROUNDS/RPC) beat cycles + stall cycles + 1.
REQ-026 SHALL keep all arithmetic 32-bit with wrap-around and no saturation.
REQ-027 SHALL make w_ready purely state-derived, with no combinational path from w_valid.

Reset
REQ-028 While rst_n=0, SHALL force state=IDLE, counter=0, w_ready=0, busy=0, done=0, digest=0, and H and working registers to 0.
REQ-029 SHALL apply reset asynchronously on the falling edge of rst_n, aborting any block in progress; the first block after release requires a fresh start.

Verification
REQ-030 Bench SHALL cover: init_state = FIPS IV (6a09e667 … 5be0cd19), start, schedule for padded "abc" with no stalls, RPC=1 -> done on cycle 65 after start, digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-031 Bench SHALL cover: the same vector with RPC=4 and random w_valid gaps -> identical digest, exactly 16 accepted beats, done one cycle after the 16th beat.
REQ-032 Bench SHALL cover: first block of the two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" vector, digest fed back as init_state for the second block -> final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 Bench SHALL cover: abort after beat 10, then an immediate new "abc" block -> no done for the aborted block, correct "abc" digest for the new block.
REQ-034 Bench SHALL cover: rst_n pulsed low mid-RUN (round 30) -> all outputs 0 within the low phase, start ignored while rst_n=0, w_ready=0 until a new start.
REQ-035 Bench SHALL cover: start pulsed during RUN and on the done cycle -> no restart or corruption; digest and done timing identical to the undisturbed run.
